// File: rtl/if_id_queue_pkg.sv
// Shared CPU constants and the IF/ID queue entry type, reused by ID and the hazard unit.
package if_id_queue_pkg;

  localparam int WORD_W  = 32;
  localparam int STALL_W = 16;

  localparam logic [WORD_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } iq_entry_t;

endpackage

// File: rtl/iq_regfile.sv
// IF/ID queue storage: DEPTH x 64-bit entries, one synchronous write port, one asynchronous read port.
module iq_regfile
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic      clk_i,
  input  logic      we_i,
  input  logic [AW-1:0] waddr_i,
  input  iq_entry_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output iq_entry_t rdata_o
);

  // Slots are never reset; the queue masks any slot that is not occupied.
  iq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// Decoupling queue between the IF and ID stages with flush, occupancy and saturating stall counter.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int                DEPTH     = 2,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     in_valid,
  input  logic [WORD_W-1:0]        in_pc,
  input  logic [WORD_W-1:0]        in_instr,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [WORD_W-1:0]        out_pc,
  output logic [WORD_W-1:0]        out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [STALL_W-1:0]       stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]      DEPTH_C   = CW'(DEPTH);
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  if (DEPTH != 2 && DEPTH != 4 && DEPTH != 8) begin : g_bad_depth
    $error("if_id_queue: DEPTH must be 2, 4 or 8");
  end

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  logic      push, pop, stall_inc;
  iq_entry_t wr_entry, head_entry;

  // Handshake: a word moves on a rising edge when valid and ready are both high
  // and flush is low. in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign stall_inc = out_valid & ~out_ready & ~flush;

  assign wr_entry.pc    = in_pc;
  assign wr_entry.instr = in_instr;

  iq_regfile #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    if (stall_inc && stall_cnt_q != STALL_MAX) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_pc    = out_valid ? head_entry.pc    : '0;
  assign out_instr = out_valid ? head_entry.instr : NOP_INSTR;
  assign count     = count_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_if_id_queue;

  localparam int          DEPTH = 2;
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          RST;
  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_ready;
  logic [CW-1:0] count;
  logic [15:0]   stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a plain FIFO of {pc, instr} words and a saturating stall count.
  logic [63:0] m_q[$];
  int          m_stall = 0;

  if_id_queue #(
    .DEPTH     (DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count),
    .stall_cnt (stall_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  always @(posedge clk or negedge RST) begin : model
    bit do_push;
    bit do_pop;
    bit full;
    bit empty;
    if (!RST) begin
      m_q.delete();
      m_stall = 0;
    end else begin
      full    = (m_q.size() >= DEPTH);
      empty   = (m_q.size() == 0);
      do_push = in_valid && !full && !flush;
      do_pop  = !empty && out_ready && !flush;
      if (!empty && !out_ready && !flush && m_stall < 65535) m_stall++;
      if (flush) begin
        m_q.delete();
      end else begin
        if (do_pop)  void'(m_q.pop_front());
        if (do_push) m_q.push_back({in_pc, in_instr});
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    e_pc    = (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
    e_instr = (m_q.size() != 0) ? m_q[0][31:0]  : NOP;
    chk("cyc_out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    chk("cyc_in_ready",  32'(in_ready),  32'(m_q.size() < DEPTH));
    chk("cyc_count",     32'(count),     32'(m_q.size()));
    chk("cyc_out_pc",    out_pc,         e_pc);
    chk("cyc_out_instr", out_instr,      e_instr);
    chk("cyc_stall_cnt", 32'(stall_cnt), 32'(m_stall));
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
  endtask

  initial begin
    RST = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) step();
    chk("rst_in_ready",  32'(in_ready),  32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_instr", out_instr,      NOP);
    chk("rst_out_pc",    out_pc,         32'h0);
    #2 RST = 1'b1;

    // First push right after reset release.
    drive(1'b1, 32'h0, 32'h2008_0005, 1'b0, 1'b0);
    step();
    chk("first_out_valid", 32'(out_valid), 32'h1);
    chk("first_out_pc",    out_pc,         32'h0);
    chk("first_out_instr", out_instr,      32'h2008_0005);
    chk("first_count",     32'(count),     32'h1);

    // Fill to full; the third word must be refused while ID stalls.
    drive(1'b1, 32'h4, 32'h1111_0004, 1'b0, 1'b0);
    step();
    chk("fill_count",    32'(count),    32'h2);
    chk("fill_in_ready", 32'(in_ready), 32'h0);
    drive(1'b1, 32'h8, 32'h1111_0008, 1'b0, 1'b0);
    repeat (3) step();
    chk("full_count",     32'(count),     32'h2);
    chk("full_out_pc",    out_pc,         32'h0);
    chk("full_stall_cnt", 32'(stall_cnt), 32'd4);

    // Flush beats a simultaneous push and pop.
    drive(1'b1, 32'h40, 32'h4444_0040, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("flush_count",     32'(count),     32'h0);
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    chk("flush_out_instr", out_instr,      NOP);
    chk("flush_stall_cnt", 32'(stall_cnt), 32'd4);
    step();
    chk("flush_no_40", 32'(out_valid), 32'h0);

    // Streaming: one word in and one out every cycle.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i * 4), 32'h5500_0000 | 32'(i), 1'b1, 1'b0);
      step();
      chk("stream_count",  32'(count), 32'h1);
      chk("stream_out_pc", out_pc,     32'(i * 4));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("stream_drained", 32'(count), 32'h0);

    // Async reset between edges with one word queued and stalling.
    drive(1'b1, 32'h100, 32'h6600_0100, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    #2 RST = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("arst_count",     32'(count),     32'h0);
    chk("arst_out_instr", out_instr,      NOP);
    step();
    RST = 1'b1;

    // Random traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
      step();
    end

    // Saturation of the stall counter.
    drive(1'b1, 32'h200, 32'h7700_0200, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (66000) step();
    chk("sat_stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    chk("sat_after_flush", 32'(stall_cnt), 32'h0000_FFFF);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (5) step();
    chk("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
